// File: rtl/vend_fsm_param.sv
// vend_fsm_param -- parametrised coin vending FSM with a CHG_UNIT change-pulse refund train (rev 1.0).
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC idle cycles in COLLECT.
`default_nettype none

module vend_fsm_param #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 15,
  parameter int COIN0_VAL   = 5,
  parameter int COIN1_VAL   = 10,
  parameter int COIN2_VAL   = 25,
  parameter int CHG_UNIT    = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                cancel,
  input  logic                dispense_ready,
  output logic                product,
  output logic                chg_pulse,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int    AW    = CREDIT_W + 1;
  localparam longint L_MAX = (longint'(1) << CREDIT_W) - 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  localparam logic [AW-1:0]       C_MAX     = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [AW-1:0]       C_PRICE_W = AW'(PRICE);
  localparam logic [CREDIT_W-1:0] C_PRICE   = CREDIT_W'(PRICE);
  localparam logic [AW-1:0]       C_COIN0   = AW'(COIN0_VAL);
  localparam logic [AW-1:0]       C_COIN1   = AW'(COIN1_VAL);
  localparam logic [AW-1:0]       C_COIN2   = AW'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] C_CHG     = CREDIT_W'(CHG_UNIT);
  // A change unit wider than the credit register can never be paid out.
  localparam bit                  CHG_FITS  = (longint'(CHG_UNIT) <= L_MAX);

  if (CREDIT_W < 1 || PRICE < 1 || CHG_UNIT < 1 || TIMEOUT_CYC < 0 ||
      COIN0_VAL < 1 || COIN1_VAL < 1 || COIN2_VAL < 1 ||
      longint'(PRICE) > L_MAX || longint'(COIN0_VAL) > L_MAX ||
      longint'(COIN1_VAL) > L_MAX || longint'(COIN2_VAL) > L_MAX) begin : g_cfg_err
    $error("vend_fsm_param: illegal parameter configuration");
  end

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                product_q, product_d;
  logic                chg_q, chg_d;
  logic                rej_q, rej_d;
  logic                busy_q, busy_d;

  logic [AW-1:0]       w_coin_val;
  logic                w_coin_ok;
  logic [AW-1:0]       w_sum;
  logic                w_accept;
  logic                w_reach;
  logic [CREDIT_W-1:0] w_rem;
  logic                w_rem_chg;
  logic                w_chg_avail;

  always_comb begin
    w_coin_val = '0;
    w_coin_ok  = 1'b1;
    case (coin_sel)
      2'd0:    w_coin_val = C_COIN0;
      2'd1:    w_coin_val = C_COIN1;
      2'd2:    w_coin_val = C_COIN2;
      default: w_coin_ok  = 1'b0;
    endcase
  end

  assign w_sum       = {1'b0, credit_q} + w_coin_val;
  assign w_accept    = coin_valid && w_coin_ok && (w_sum <= C_MAX);
  assign w_reach     = (w_sum >= C_PRICE_W);
  assign w_rem       = credit_q - C_PRICE;
  assign w_rem_chg   = CHG_FITS && (w_rem >= C_CHG);
  assign w_chg_avail = CHG_FITS && (credit_q >= C_CHG);

`ifdef VEND_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  if (TIMEOUT_CYC < 1) begin : g_tmo_cfg_err
    $error("vend_fsm_param: TIMEOUT_CYC must be >= 1 with VEND_TIMEOUT_EN");
  end

  logic [TW-1:0] tmo_q, tmo_d;
  logic          w_tmo_hit;

  assign w_tmo_hit = (tmo_q == TMO_LAST);
  // Counts only while staying in COLLECT without an accepted coin; anything else restarts it.
  assign tmo_d = (state_q == S_COLLECT && state_d == S_COLLECT && !w_accept) ?
                 tmo_q + TW'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    product_d = 1'b0;
    chg_d     = 1'b0;
    rej_d     = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (state_q == S_COLLECT && cancel) begin
          // Cancel beats a simultaneous coin: refund only what was already held.
          state_d = S_CHANGE;
          rej_d   = coin_valid;
        end else if (w_accept) begin
          credit_d = w_sum[CREDIT_W-1:0];
          state_d  = w_reach ? S_VEND : S_COLLECT;
        end else begin
          rej_d = coin_valid;
`ifdef VEND_TIMEOUT_EN
          if (state_q == S_COLLECT && w_tmo_hit) begin
            state_d = S_CHANGE;
          end
`endif
        end
      end
      S_VEND: begin
        rej_d = coin_valid;
        if (dispense_ready) begin
          product_d = 1'b1;
          if (w_rem_chg) begin
            credit_d = w_rem;
            state_d  = S_CHANGE;
          end else begin
            credit_d = '0;
            state_d  = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        rej_d = coin_valid;
        if (w_chg_avail) begin
          chg_d    = 1'b1;
          credit_d = credit_q - C_CHG;
        end else begin
          credit_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      credit_q  <= '0;
      product_q <= 1'b0;
      chg_q     <= 1'b0;
      rej_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      product_q <= product_d;
      chg_q     <= chg_d;
      rej_q     <= rej_d;
      busy_q    <= busy_d;
    end
  end

  assign product     = product_q;
  assign chg_pulse   = chg_q;
  assign coin_reject = rej_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_fsm_param.sv
// tb_vend_fsm_param -- directed and random checks of two vend_fsm_param instances (PRICE 15 and 255)
// against a credit/pulse-count reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_vend_fsm_param;

  localparam int CHG  = 5;
  localparam int MAXC = 255;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       cancel;
  logic       dispense_ready;
  logic [1:0] prod, chgp, rej, bsy;
  logic [7:0] cred [2];

  int errors = 0;
  int checks = 0;

  int m_credit [2];
  bit m_vend   [2];
  int m_ref    [2];
  int m_idle   [2];
  bit e_prod   [2];
  bit e_chg    [2];
  bit e_rej    [2];
  int n_prod   [2];
  int n_chg    [2];

  always #5 clk = ~clk;

  vend_fsm_param #(.CREDIT_W(8), .PRICE(15), .COIN0_VAL(5), .COIN1_VAL(10), .COIN2_VAL(25),
                   .CHG_UNIT(5), .TIMEOUT_CYC(TMO)) u_dut0 (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel), .cancel(cancel),
    .dispense_ready(dispense_ready), .product(prod[0]), .chg_pulse(chgp[0]),
    .coin_reject(rej[0]), .busy(bsy[0]), .credit(cred[0]));

  vend_fsm_param #(.CREDIT_W(8), .PRICE(255), .COIN0_VAL(5), .COIN1_VAL(10), .COIN2_VAL(25),
                   .CHG_UNIT(5), .TIMEOUT_CYC(TMO)) u_dut1 (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel), .cancel(cancel),
    .dispense_ready(dispense_ready), .product(prod[1]), .chg_pulse(chgp[1]),
    .coin_reject(rej[1]), .busy(bsy[1]), .credit(cred[1]));

  function automatic int price_of(input int i);
    return (i == 0) ? 15 : 255;
  endfunction

  function automatic int coin_value(input logic [1:0] s);
    case (s)
      2'd0:    return 5;
      2'd1:    return 10;
      2'd2:    return 25;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_credit[i] = 0; m_vend[i] = 0; m_ref[i] = 0; m_idle[i] = 0;
    end
  endtask

  // A refund of c credit pays floor(c/CHG) pulses plus one closing cycle.
  task automatic start_refund(input int i);
    m_ref[i]  = m_credit[i] / CHG + 1;
    m_idle[i] = 0;
  endtask

  task automatic model_step(input int i);
    int v;
    e_prod[i] = 0; e_chg[i] = 0; e_rej[i] = 0;
    if (m_ref[i] > 0) begin
      e_rej[i] = coin_valid;
      if (m_ref[i] > 1) begin
        e_chg[i] = 1;
        m_credit[i] -= CHG;
      end else begin
        m_credit[i] = 0;
      end
      m_ref[i]--;
    end else if (m_vend[i]) begin
      e_rej[i] = coin_valid;
      if (dispense_ready) begin
        e_prod[i] = 1;
        m_vend[i] = 0;
        m_credit[i] -= price_of(i);
        if (m_credit[i] >= CHG) start_refund(i);
        else m_credit[i] = 0;
      end
    end else if (m_credit[i] > 0 && cancel) begin
      e_rej[i] = coin_valid;
      start_refund(i);
    end else begin
      v = coin_value(coin_sel);
      if (coin_valid && v > 0 && m_credit[i] + v <= MAXC) begin
        m_credit[i] += v;
        m_idle[i] = 0;
        if (m_credit[i] >= price_of(i)) m_vend[i] = 1;
      end else begin
        e_rej[i] = coin_valid;
        if (m_credit[i] > 0) begin
          m_idle[i]++;
`ifdef VEND_TIMEOUT_EN
          if (m_idle[i] == TMO) start_refund(i);
`endif
        end
      end
    end
  endtask

  task automatic step(input bit cv, input logic [1:0] sel, input bit can, input bit rdy);
    coin_valid = cv; coin_sel = sel; cancel = can; dispense_ready = rdy;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d product", i), prod[i], e_prod[i]);
      check($sformatf("d%0d chg_pulse", i), chgp[i], e_chg[i]);
      check($sformatf("d%0d coin_reject", i), rej[i], e_rej[i]);
      check($sformatf("d%0d busy", i), bsy[i], (m_vend[i] || m_ref[i] > 0));
      check($sformatf("d%0d credit", i), cred[i], m_credit[i]);
      if (prod[i] === 1'b1) n_prod[i]++;
      if (chgp[i] === 1'b1) n_chg[i]++;
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin n_prod[i] = 0; n_chg[i] = 0; end
  endtask

  task automatic flush();
    step(0, 2'd0, 1, 0);
    repeat (60) step(0, 2'd0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; coin_valid = 0; coin_sel = 0; cancel = 0; dispense_ready = 0;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset product", prod[i], 0);
      check("reset chg_pulse", chgp[i], 0);
      check("reset coin_reject", rej[i], 0);
      check("reset busy", bsy[i], 0);
      check("reset credit", cred[i], 0);
    end
    rst = 1'b0;

    // Exact price from 10 + 5, no change.
    step(1, 2'd1, 0, 1);
    check("A credit10", cred[0], 10);
    step(1, 2'd0, 0, 1);
    check("A credit15", cred[0], 15);
    check("A busy vend", bsy[0], 1);
    step(0, 2'd0, 0, 1);
    check("A product", prod[0], 1);
    repeat (3) step(0, 2'd0, 0, 0);
    check("A nprod", n_prod[0], 1);
    check("A nchg", n_chg[0], 0);
    check("A idle credit", cred[0], 0);
    flush();

    // Coin 25, dispenser late, 10 of change.
    clr_counts();
    step(1, 2'd2, 0, 0);
    repeat (5) step(0, 2'd0, 0, 0);
    check("B no early product", n_prod[0], 0);
    step(0, 2'd0, 0, 1);
    check("B product", prod[0], 1);
    check("B remainder", cred[0], 10);
    repeat (5) step(0, 2'd0, 0, 0);
    check("B nchg", n_chg[0], 2);
    check("B nprod", n_prod[0], 1);
    check("B busy end", bsy[0], 0);
    flush();

    // Cancel refunds; cancel with a coin refunds only prior credit.
    clr_counts();
    step(1, 2'd0, 0, 0);
    step(0, 2'd0, 1, 0);
    repeat (4) step(0, 2'd0, 0, 0);
    check("C nchg", n_chg[0], 1);
    check("C nprod", n_prod[0], 0);
    clr_counts();
    step(1, 2'd0, 0, 0);
    step(1, 2'd0, 1, 0);
    check("C cancel+coin reject", rej[0], 1);
    check("C cancel+coin credit", cred[0], 5);
    repeat (4) step(0, 2'd0, 0, 0);
    check("C2 nchg", n_chg[0], 1);
    flush();

    // Rejections: invalid select, coin during CHANGE, overflow.
    step(1, 2'd3, 0, 0);
    check("D sel3 reject", rej[0], 1);
    check("D sel3 credit", cred[0], 0);
    step(1, 2'd1, 0, 0);
    step(0, 2'd0, 1, 0);
    step(1, 2'd0, 0, 0);
    check("D change reject", rej[0], 1);
    check("D change credit", cred[0], 5);
    flush();
    repeat (10) step(1, 2'd2, 0, 0);
    check("D hi credit250", cred[1], 250);
    step(1, 2'd1, 0, 0);
    check("D overflow reject", rej[1], 1);
    check("D overflow credit", cred[1], 250);
    step(1, 2'd0, 0, 0);
    check("D hi credit255", cred[1], 255);
    step(0, 2'd0, 0, 1);
    check("D hi product", prod[1], 1);
    check("D hi credit0", cred[1], 0);
    flush();

    // Asynchronous reset in the middle of a change train.
    step(1, 2'd2, 0, 0);
    step(0, 2'd0, 0, 1);
    check("E in change", bsy[0], 1);
    #3 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("E rst credit", cred[i], 0);
      check("E rst product", prod[i], 0);
      check("E rst chg", chgp[i], 0);
      check("E rst busy", bsy[i], 0);
    end
    rst = 1'b0;
    clr_counts();
    repeat (5) step(0, 2'd0, 0, 0);
    check("E no pulses", n_chg[0], 0);

`ifdef VEND_TIMEOUT_EN
    flush();
    clr_counts();
    step(1, 2'd0, 0, 0);
    repeat (7) step(0, 2'd0, 0, 0);
    check("F not yet", bsy[0], 0);
    step(0, 2'd0, 0, 0);
    check("F timeout", bsy[0], 1);
    repeat (3) step(0, 2'd0, 0, 0);
    check("F nchg", n_chg[0], 1);
    clr_counts();
    step(1, 2'd0, 0, 0);
    repeat (6) step(0, 2'd0, 0, 0);
    step(1, 2'd0, 0, 0);
    repeat (7) step(0, 2'd0, 0, 0);
    check("F restart not yet", bsy[0], 0);
    step(0, 2'd0, 0, 0);
    check("F restart timeout", bsy[0], 1);
    repeat (4) step(0, 2'd0, 0, 0);
    check("F2 nchg", n_chg[0], 2);
`endif

    flush();
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
- Parametrised coin-operated vending controller; next generation of the two-input product/change FSM.
- Accepts up to three coin denominations through a valid-qualified select bus and accumulates a binary credit.
- Vends when credit reaches PRICE, waiting on a dispenser handshake.
- Returns excess credit, or the full credit on cancel, as a train of single-cycle change pulses of value CHG_UNIT.

Parameters:
- CREDIT_W, 8: credit register width.
- PRICE, 15: product price in credit units.
- COIN0_VAL, 5: value of coin_sel=0.
- COIN1_VAL, 10: value of coin_sel=1.
- COIN2_VAL, 25: value of coin_sel=2.
- CHG_UNIT, 5: value returned per chg_pulse.
- TIMEOUT_CYC, 64: idle cycles before auto-refund; used only with VEND_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- coin_valid  input  1  coin present this cycle.
- coin_sel  input  2  denomination; 3 is invalid.
- cancel  input  1  request refund of the current credit.
- dispense_ready  input  1  dispenser can accept a vend.
- product  output  1  one-cycle vend pulse.
- chg_pulse  output  1  one-cycle pulse, each worth CHG_UNIT.
- coin_reject  output  1  one-cycle pulse: coin not accepted.
- busy  output  1  high in VEND or CHANGE.
- credit  output  CREDIT_W  current credit, registered.

Behaviour:
- Reset: the asynchronous reset (rst, active-high; clock clk) forces state=IDLE and credit=0. product, chg_pulse, coin_reject and busy are all 0.
- All outputs are registered. product, chg_pulse and coin_reject are high for one cycle per event and are otherwise 0.
- States: IDLE, COLLECT, VEND, CHANGE. Encoding is 2 bits; any illegal encoding returns to IDLE with credit=0.
- IDLE/COLLECT, coin acceptance:
  - A coin is accepted when coin_valid=1, coin_sel<3, and credit+value does not exceed 2^CREDIT_W-1.
  - Accepted coin: credit <= credit+value at the next edge.
  - Otherwise: coin_reject=1 the next cycle and credit is unchanged.
- IDLE: an accepted coin moves to COLLECT, or directly to VEND if the new credit >= PRICE. cancel is ignored in IDLE.
- COLLECT:
  - An accepted coin with new credit >= PRICE goes to VEND; otherwise stay in COLLECT.
  - cancel=1 goes to CHANGE with credit kept (full refund).
  - cancel and coin_valid in the same cycle: cancel wins, the coin is rejected (coin_reject=1).
- VEND:
  - Wait for dispense_ready=1 at a rising edge. There is no timeout.
  - On that edge: product=1 next cycle, credit <= credit-PRICE, then go to CHANGE if the remainder >= CHG_UNIT, else IDLE with credit=0.
  - cancel is ignored in VEND.
- CHANGE:
  - At each edge, if credit >= CHG_UNIT: chg_pulse=1 and credit <= credit-CHG_UNIT.
  - Otherwise: credit <= 0 (any sub-unit residue is discarded), chg_pulse=0, go to IDLE.
  - Refunding N units therefore takes N+1 cycles.
- Coins arriving in VEND or CHANGE are rejected (coin_reject=1); credit is unaffected.
- busy = (state is VEND or CHANGE), registered with the state.
- Reset mid-VEND or mid-CHANGE: credit is cleared and no further pulses are issued.
- Parameter rules:
  - PRICE and all COINn_VAL must be <= 2^CREDIT_W-1 and >= 1.
  - CHG_UNIT >= 1.
  - A value of 0 for any of these is a configuration error.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- With it defined:
  - A counter of width clog2(TIMEOUT_CYC+1) runs in COLLECT.
  - It clears on any accepted coin and on entry to COLLECT.
  - On reaching TIMEOUT_CYC, the FSM goes to CHANGE exactly as if cancel had been asserted.
  - The counter resets to 0 with rst.
- Without it: there is no counter, COLLECT waits indefinitely, and TIMEOUT_CYC is unused.

Test Plan:
- Reset: assert rst mid-CHANGE for 2 cycles -> credit=0, product=0, chg_pulse=0, busy=0, state IDLE; no pulses after release.
- Coin 10 then coin 5, dispense_ready=1 -> credit goes 10, then 15; VEND; product one pulse; no chg_pulse; credit=0; back to IDLE.
- Coin 25, dispense_ready held 0 for 5 cycles then 1 -> product only after ready; credit=10; exactly 2 chg_pulse; credit=0; IDLE.
- Coin 5 then cancel -> 1 chg_pulse, credit=0, no product. Coin 5 with cancel in the same cycle from COLLECT -> coin_reject=1 and refund of the prior credit only.
- coin_sel=3, a coin during CHANGE, and credit=250 plus a 10 coin (CREDIT_W=8) -> coin_reject pulse each time; credit unchanged.
- VEND_TIMEOUT_EN with TIMEOUT_CYC=8: coin 5, then idle 8 cycles -> entry to CHANGE, 1 chg_pulse. A coin at cycle 7 restarts the count.
